// File: rtl/txn_pkg.sv
// Shared definitions for the transaction commit stage: FSM state encoding,
// result codes reported to the control layer, and the account index width.
package txn_pkg;

    localparam int ACCT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_REPORT = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ST_OK       = 3'd0,
        ST_BAD_KEY  = 3'd1,
        ST_NO_FUNDS = 3'd2,
        ST_OVERFLOW = 3'd3,
        ST_TIMEOUT  = 3'd4,
        ST_SELF     = 3'd5
    } status_e;

endpackage

// File: rtl/balance_regfile.sv
// Account balance storage: NUM_ACCT registers, two read ports for the transfer
// parties, one external read port, and a single strobe that writes both parties.
module balance_regfile
    import txn_pkg::*;
#(
    parameter int                NUM_ACCT = 4,
    parameter int                AMT_W    = 8,
    parameter logic [AMT_W-1:0]  INIT_BAL = 8'd100
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ACCT_W-1:0] snd_addr,
    output logic [AMT_W-1:0]  snd_data,
    input  logic [ACCT_W-1:0] rcv_addr,
    output logic [AMT_W-1:0]  rcv_data,
    input  logic [ACCT_W-1:0] rd_addr,
    output logic [AMT_W-1:0]  rd_data,
    input  logic              commit,
    input  logic [AMT_W-1:0]  snd_wdata,
    input  logic [AMT_W-1:0]  rcv_wdata
);

    logic [AMT_W-1:0] bal [NUM_ACCT];

    assign snd_data = bal[snd_addr];
    assign rcv_data = bal[rcv_addr];
    assign rd_data  = bal[rd_addr];

    // NOTE: this is a tiny flop array, not a RAM macro, so every entry can and
    // must take a reset value; a real SRAM would be initialised by a sequencer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                bal[i] <= INIT_BAL;
            end
        end else if (commit) begin
            // Both parties update on the same edge; they are distinct by construction.
            bal[snd_addr] <= snd_wdata;
            bal[rcv_addr] <= rcv_wdata;
        end
    end

endmodule

// File: rtl/transaction_commit.sv
// Transfer engine: latches a request, waits for the key verdict, checks funds
// and receiver overflow, then commits both balance updates atomically.
module transaction_commit
    import txn_pkg::*;
#(
    parameter int                NUM_ACCT       = 4,
    parameter int                AMT_W          = 8,
    parameter logic [AMT_W-1:0]  INIT_BAL       = 8'd100,
    parameter int                VERIFY_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ACCT_W-1:0] sender,
    input  logic [ACCT_W-1:0] receiver,
    input  logic [AMT_W-1:0]  amount,
    output logic              verify_start,
    input  logic              verify_done,
    input  logic              verify_ok,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    input  logic [ACCT_W-1:0] rd_addr,
    output logic [AMT_W-1:0]  rd_data
);

    localparam int CNT_W = $clog2(VERIFY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VERIFY_TIMEOUT - 1);

    state_e            state;
    status_e           status_q;
    logic [ACCT_W-1:0] snd_q;
    logic [ACCT_W-1:0] rcv_q;
    logic [AMT_W-1:0]  amt_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [AMT_W-1:0]  snd_bal;
    logic [AMT_W-1:0]  rcv_bal;
    logic [AMT_W:0]    rcv_sum;
    logic [AMT_W-1:0]  snd_diff;
    logic              commit;

    status_e           chk_status;
    logic              chk_pass;

    assign status   = status_q;
    assign commit   = (state == S_COMMIT);
    assign rcv_sum  = {1'b0, rcv_bal} + {1'b0, amt_q};
    assign snd_diff = snd_bal - amt_q;

    balance_regfile #(
        .NUM_ACCT (NUM_ACCT),
        .AMT_W    (AMT_W),
        .INIT_BAL (INIT_BAL)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .snd_addr  (snd_q),
        .snd_data  (snd_bal),
        .rcv_addr  (rcv_q),
        .rcv_data  (rcv_bal),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .commit    (commit),
        .snd_wdata (snd_diff),
        .rcv_wdata (rcv_sum[AMT_W-1:0])
    );

    // NOTE: every output of this block gets a default before the if-chain, so
    // no path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        chk_status = ST_OK;
        chk_pass   = 1'b0;
        if (snd_q == rcv_q) begin
            chk_status = ST_SELF;
        end else if (snd_bal < amt_q) begin
            chk_status = ST_NO_FUNDS;
        end else if (rcv_sum[AMT_W]) begin
            chk_status = ST_OVERFLOW;
        end else begin
            chk_pass = 1'b1;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignment so every
    // branch sees the pre-edge values, matching what the flops actually do.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            status_q     <= ST_OK;
            snd_q        <= '0;
            rcv_q        <= '0;
            amt_q        <= '0;
            cnt_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            verify_start <= 1'b0;
        end else begin
            verify_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snd_q        <= sender;
                        rcv_q        <= receiver;
                        amt_q        <= amount;
                        cnt_q        <= '0;
                        status_q     <= ST_OK;
                        busy         <= 1'b1;
                        verify_start <= 1'b1;
                        state        <= S_WAIT;
                    end
                end

                // A verdict arriving on the timeout cycle takes precedence.
                S_WAIT: begin
                    if (verify_done) begin
                        if (verify_ok) begin
                            state <= S_CHECK;
                        end else begin
                            status_q <= ST_BAD_KEY;
                            done     <= 1'b1;
                            state    <= S_REPORT;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        status_q <= ST_TIMEOUT;
                        done     <= 1'b1;
                        state    <= S_REPORT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (chk_pass) begin
                        state <= S_COMMIT;
                    end else begin
                        status_q <= chk_status;
                        done     <= 1'b1;
                        state    <= S_REPORT;
                    end
                end

                // The regfile write happens on this same edge via the commit strobe.
                S_COMMIT: begin
                    status_q <= ST_OK;
                    done     <= 1'b1;
                    state    <= S_REPORT;
                end

                S_REPORT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transaction_commit.sv
// Self-checking bench for transaction_commit: a vector table of transfers with
// hand-computed results, a done/status scoreboard, and reset/busy corner sequences.
module tb_transaction_commit;

    localparam int AMT_W = 8;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [1:0]       sender;
    logic [1:0]       receiver;
    logic [AMT_W-1:0] amount;
    logic             verify_start;
    logic             verify_done;
    logic             verify_ok;
    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic [1:0]       rd_addr;
    logic [AMT_W-1:0] rd_data;

    transaction_commit #(
        .NUM_ACCT       (4),
        .AMT_W          (AMT_W),
        .INIT_BAL       (8'd100),
        .VERIFY_TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .sender       (sender),
        .receiver     (receiver),
        .amount       (amount),
        .verify_start (verify_start),
        .verify_done  (verify_done),
        .verify_ok    (verify_ok),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]       s;
        logic [1:0]       r;
        logic [7:0]       amt;
        int               k;      // verdict edge after acceptance; 0 = never
        bit               ok;
        bit               poke;   // issue stray start/verify_done while busy
        logic [2:0]       st;
        logic [3:0][7:0]  bal;    // expected balances afterwards, [a] = account a
    } vec_t;

    typedef struct {
        logic [2:0] st;
        int         edge_no;
    } sb_t;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   edge_cnt   = 0;
    int   vs_count   = 0;
    int   n_started  = 0;
    sb_t  sb_q[$];
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0][7:0] bals(input logic [7:0] b0, b1, b2, b3);
        logic [3:0][7:0] b;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        return b;
    endfunction

    function automatic vec_t mk(input logic [1:0] s, r, input logic [7:0] amt, input int k,
                                input bit ok, poke, input logic [2:0] st, input logic [3:0][7:0] bal);
        vec_t v;
        v.s = s; v.r = r; v.amt = amt; v.k = k; v.ok = ok; v.poke = poke; v.st = st; v.bal = bal;
        return v;
    endfunction

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Scoreboard: each done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (verify_start) vs_count++;
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual status %0d, required no done pulse (t=%0t)", status, $time);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_status", status, e.st);
                check("sb_done_edge", edge_cnt, e.edge_no);
            end
        end
    end

    task automatic check_bals(input string tag, input logic [3:0][7:0] exp);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            check($sformatf("%s_bal%0d", tag, a), rd_data, exp[a]);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  n_edge;
        int  lat;
        int  i;
        bit  seen;
        sb_t e;

        if (v.k == 0)      lat = 16;
        else if (!v.ok)    lat = v.k;
        else if (v.st == 3'd0) lat = v.k + 2;
        else               lat = v.k + 1;

        @(negedge clock);
        start    = 1'b1;
        sender   = v.s;
        receiver = v.r;
        amount   = v.amt;
        n_edge   = edge_cnt + 1;
        e.st     = v.st;
        e.edge_no = n_edge + lat;
        sb_q.push_back(e);
        n_started++;

        @(negedge clock);
        start    = 1'b0;
        sender   = ~v.s;
        receiver = ~v.r;
        amount   = ~v.amt;
        check($sformatf("v%0d_verify_start", idx), verify_start, 1);
        check($sformatf("v%0d_busy_wait", idx), busy, 1);

        i = 0;
        seen = 1'b0;
        while (!seen && i < 40) begin
            i++;
            verify_ok   = v.ok;
            verify_done = (v.k != 0 && i == v.k) ||
                          (v.poke && v.k != 0 && i == v.k + 1);
            if (v.poke && i == 2) begin
                start    = 1'b1;
                sender   = 2'd3;
                receiver = 2'd2;
                amount   = 8'd7;
            end
            @(negedge clock);
            start       = 1'b0;
            verify_done = 1'b0;
            seen        = done;
        end
        if (!seen) begin
            check($sformatf("v%0d_done_seen", idx), 0, 1);
            return;
        end

        check($sformatf("v%0d_busy_report", idx), busy, 1);
        start       = 1'b1;
        sender      = 2'd1;
        receiver    = 2'd2;
        amount      = 8'd3;
        verify_done = 1'b1;
        verify_ok   = 1'b1;
        @(negedge clock);
        start       = 1'b0;
        verify_done = 1'b0;
        check($sformatf("v%0d_done_width", idx), done, 0);
        check($sformatf("v%0d_busy_idle", idx), busy, 0);
        check($sformatf("v%0d_no_restart", idx), verify_start, 0);
        check($sformatf("v%0d_status_held", idx), status, v.st);
        check_bals($sformatf("v%0d", idx), v.bal);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        sender      = '0;
        receiver    = '0;
        amount      = '0;
        verify_done = 1'b0;
        verify_ok   = 1'b0;
        rd_addr     = '0;

        //               s  r  amt  k  ok poke st  balances after
        vecs[0]  = mk(0, 1,  30,  3, 0, 0, 1, bals( 100, 100, 100, 100));
        vecs[1]  = mk(0, 1,  30,  8, 1, 1, 0, bals(  70, 130, 100, 100));
        vecs[2]  = mk(2, 0, 101,  2, 1, 0, 2, bals(  70, 130, 100, 100));
        vecs[3]  = mk(0, 3,  50,  1, 1, 0, 0, bals(  20, 130, 100, 150));
        vecs[4]  = mk(1, 3,  50, 15, 1, 1, 0, bals(  20,  80, 100, 200));
        vecs[5]  = mk(2, 3,  60,  4, 1, 0, 3, bals(  20,  80, 100, 200));
        vecs[6]  = mk(2, 3,  55,  2, 1, 0, 0, bals(  20,  80,  45, 255));
        vecs[7]  = mk(1, 3,   1,  1, 1, 1, 3, bals(  20,  80,  45, 255));
        vecs[8]  = mk(1, 1,  10,  5, 1, 0, 5, bals(  20,  80,  45, 255));
        vecs[9]  = mk(2, 0,   0,  3, 1, 0, 0, bals(  20,  80,  45, 255));
        vecs[10] = mk(0, 1,   5,  0, 1, 1, 4, bals(  20,  80,  45, 255));
        vecs[11] = mk(0, 1,   5, 16, 1, 0, 0, bals(  15,  85,  45, 255));
        vecs[12] = mk(2, 1,  45,  2, 1, 0, 0, bals(  15, 130,   0, 255));
        vecs[13] = mk(2, 0,   1,  6, 1, 0, 2, bals(  15, 130,   0, 255));
        vecs[14] = mk(3, 0, 255,  3, 1, 0, 3, bals(  15, 130,   0, 255));
        vecs[15] = mk(3, 2, 255,  1, 1, 0, 0, bals(  15, 130, 255,   0));
        vecs[16] = mk(0, 1,   5, 16, 0, 0, 1, bals(  15, 130, 255,   0));
        vecs[17] = mk(0, 1,   5,  0, 0, 0, 4, bals(  15, 130, 255,   0));
        vecs[18] = mk(0, 0, 200,  2, 1, 1, 5, bals(  15, 130, 255,   0));

        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_verify_start", verify_start, 0);
        check("rst_status", status, 0);
        check_bals("rst", bals(100, 100, 100, 100));

        for (int i = 0; i < 19; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of WAIT aborts the request and restores balances.
        @(negedge clock);
        start    = 1'b1;
        sender   = 2'd1;
        receiver = 2'd0;
        amount   = 8'd50;
        n_started++;
        @(negedge clock);
        start = 1'b0;
        check("midrst_busy_before", busy, 1);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_status", status, 0);
        check_bals("midrst", bals(100, 100, 100, 100));
        @(negedge clock);
        verify_done = 1'b1;
        verify_ok   = 1'b1;
        @(negedge clock);
        verify_done = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_verify_start", verify_start, 0);
        repeat (4) @(negedge clock);
        check("stray_busy_late", busy, 0);
        check("stray_status", status, 0);
        check_bals("stray", bals(100, 100, 100, 100));

        check("verify_start_pulses", vs_count, n_started);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/transaction_commit.md
Name: transaction_commit

Overview:
- Downstream consumer of the key-verification stage in the datapath.
- Accepts a transfer request (sender, receiver, amount) and waits for the verification verdict on the sender's key.
- On a valid key it checks funds and overflow, then atomically updates a small on-chip balance register file.
- Reports a completion pulse plus a status code to the control/display layer; balances are readable through a side port.

Parameters:
- NUM_ACCT, 4, number of accounts; the account index is 2 bits wide.
- AMT_W, 8, width of amounts and balances.
- INIT_BAL, 8'd100, balance loaded into every account on reset.
- VERIFY_TIMEOUT, 16, cycles to wait for a verdict before aborting.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- sender  in  2  paying account index.
- receiver  in  2  receiving account index.
- amount  in  AMT_W  transfer amount.
- verify_start  out  1  one-cycle pulse that restarts the key-verification/hash stage.
- verify_done  in  1  one-cycle pulse: verdict valid.
- verify_ok  in  1  verdict (1 = key correct); qualified by verify_done.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  3  result code; held from done until the next accepted start.
- rd_addr  in  2  balance read address.
- rd_data  out  AMT_W  balance[rd_addr]; combinational read of the register file.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; all balances=INIT_BAL.
  - busy=0, done=0, verify_start=0, status=0.
  - Timeout counter and request latches cleared.
  - Reset asserted mid-transaction aborts it with no balance change.
- Status codes (shared package):
  - 0 OK, 1 BAD_KEY, 2 NO_FUNDS, 3 OVERFLOW, 4 TIMEOUT, 5 SELF.
- IDLE:
  - start=1 latches sender/receiver/amount.
  - Drives verify_start=1 for that one cycle; next state is WAIT.
  - Inputs changing after acceptance are ignored.
- WAIT:
  - Counter increments each cycle.
  - verify_done=1 with verify_ok=1 -> CHECK.
  - verify_done=1 with verify_ok=0 -> REPORT, status=BAD_KEY.
  - Counter reaching VERIFY_TIMEOUT-1 with no verify_done -> REPORT, status=TIMEOUT.
  - verify_done on the same cycle as the timeout: the verdict wins.
  - verify_done pulses in IDLE, CHECK, COMMIT or REPORT are ignored.
- CHECK, in priority order:
  - sender==receiver -> status=SELF, no change.
  - balance[sender] < amount -> NO_FUNDS.
  - balance[receiver]+amount > 2^AMT_W-1 (carry out) -> OVERFLOW.
  - Otherwise -> COMMIT.
  - A SELF/NO_FUNDS/OVERFLOW result goes to REPORT.
- COMMIT (one cycle):
  - balance[sender] -= amount and balance[receiver] += amount on the same edge.
  - status=OK; next state is REPORT.
  - amount=0 is legal and commits with no net change.
- REPORT:
  - done=1 for exactly one cycle; next state is IDLE.
  - start during REPORT is ignored.
- Latency, successful path:
  - start accepted at edge N, verdict seen at edge N+k (k≥1).
  - CHECK at N+k+1, COMMIT at N+k+2, done high during the cycle after N+k+2.
  - The balance change is visible on rd_data from edge N+k+2.
- Arithmetic:
  - Unsigned; the overflow check uses an AMT_W+1-bit sum.
  - No wrap-around is ever written to a balance.

Decomposition:
- Package txn_pkg holds:
  - the state encoding (IDLE, WAIT, CHECK, COMMIT, REPORT);
  - the status code constants;
  - the account-index width.
- One sub-module, balance_regfile:
  - NUM_ACCT×AMT_W registers with synchronous reset to INIT_BAL;
  - two combinational read ports (sender and receiver) plus the external rd port;
  - one dual-write commit strobe.
- The FSM, timeout counter and checks live in transaction_commit.

Test Plan:
- Successful transfer: reset, then start with sender=0, receiver=1, amount=30, then verify_done+ok after 8 cycles -> done pulse, status=0, balance0=70, balance1=130, verify_start pulsed once.
- Rejected key: same request with verify_ok=0 -> status=1, balances 100/100, busy drops the cycle after done.
- Funds checks: sender=2, amount=101 -> status=2. Then pre-load account3 to 200 via two transfers, and transfer 60 into it -> status=3. Balances unchanged in both cases.
- Timeout and edge requests:
  - No verify_done for 16 cycles -> status=4, done at the expected cycle.
  - verify_done on the timeout cycle -> verdict honoured.
  - sender==receiver -> status=5.
  - amount=0 -> OK with balances unchanged.
- Reset mid-WAIT: reset_n=0 for one cycle -> busy=0, status=0, all balances 100. A later stray verify_done causes no state change.
- Start while busy: a second start during WAIT and REPORT -> ignored; the first request's latched values are used and exactly one done pulse occurs.
